csi2_packet_extractor: RTL and testbench

Parses the 32-bit merged four-lane CSI-2 byte stream from the lane aligner into packets, strips each long packet's header and CRC, and forwards the payload words of the selected data type and virtual channel. Sits directly upstream of the RGB888 pixel decoder: its `image_data` / `image_data_enable` outputs drive that decoder unchanged. Also decodes frame-start/frame-end short packets into single-cycle pulses.

---
 rtl/csi2_packet_extractor_if.sv | 24 ++
 rtl/csi2_packet_extractor.sv | 144 ++++++++++++++
 tb/tb_csi2_packet_extractor.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/csi2_packet_extractor_if.sv
// Merged CSI-2 lane word stream in, payload words and packet event pulses out.
interface csi2_packet_extractor_if;
  logic [31:0] data;
  logic        data_valid;
  logic [31:0] image_data;
  logic        image_data_enable;
  logic        frame_start;
  logic        frame_end;
  logic        line_start;
  logic [15:0] packet_word_count;
  logic        truncated;

  modport master (
    output data, data_valid,
    input  image_data, image_data_enable, frame_start, frame_end,
    input  line_start, packet_word_count, truncated
  );

  modport slave (
    input  data, data_valid,
    output image_data, image_data_enable, frame_start, frame_end,
    output line_start, packet_word_count, truncated
  );
endinterface

// File: rtl/csi2_packet_extractor.sv
// Splits the merged CSI-2 word stream into packets and forwards the selected long-packet payload.
// Latency 1 cycle, all outputs registered; no backpressure, one word per cycle.
module csi2_packet_extractor #(
  parameter logic [5:0] DATA_TYPE       = 6'h24,
  parameter logic [1:0] VIRTUAL_CHANNEL = 2'd0
) (
  input logic                    clock,
  input logic                    reset,
  csi2_packet_extractor_if.slave bus
);
  typedef enum logic [1:0] {IDLE, PAYLOAD, TRAIL, WAIT_END} state_t;

  state_t      state_q, state_d;
  logic [14:0] pay_cnt_q, pay_cnt_d;
  logic        trail_cnt_q, trail_cnt_d;
  logic [15:0] word_count_q, word_count_d;
  logic [31:0] image_data_q, image_data_d;
  logic        image_data_enable_q, image_data_enable_d;
  logic        frame_start_q, frame_start_d;
  logic        frame_end_q, frame_end_d;
  logic        line_start_q, line_start_d;
  logic        truncated_q, truncated_d;

  logic [1:0]  hdr_vc;
  logic [5:0]  hdr_dt;
  logic [15:0] hdr_wc;
  logic [14:0] hdr_words;
  logic        hdr_trail;
  logic        hdr_vc_ok;
  logic [31:0] last_mask;

  assign hdr_vc    = bus.data[7:6];
  assign hdr_dt    = bus.data[5:0];
  assign hdr_wc    = {bus.data[23:16], bus.data[15:8]};
  assign hdr_vc_ok = (hdr_vc == VIRTUAL_CHANNEL);
  assign hdr_words = {1'b0, hdr_wc[15:2]} + {14'd0, |hdr_wc[1:0]};
  // The 2-byte CRC spills into its own word only when WC mod 4 is 0 or 3.
  assign hdr_trail = (hdr_wc[1:0] == 2'd0) || (hdr_wc[1:0] == 2'd3);

  always_comb begin
    last_mask = 32'hFFFF_FFFF;
    case (word_count_q[1:0])
      2'd1:    last_mask = 32'h0000_00FF;
      2'd2:    last_mask = 32'h0000_FFFF;
      2'd3:    last_mask = 32'h00FF_FFFF;
      default: last_mask = 32'hFFFF_FFFF;
    endcase
  end

  always_comb begin
    state_d             = state_q;
    pay_cnt_d           = pay_cnt_q;
    trail_cnt_d         = trail_cnt_q;
    word_count_d        = word_count_q;
    image_data_d        = image_data_q;
    image_data_enable_d = 1'b0;
    frame_start_d       = 1'b0;
    frame_end_d         = 1'b0;
    line_start_d        = 1'b0;
    truncated_d         = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.data_valid) begin
          if (hdr_dt < 6'h10) begin
            frame_start_d = (hdr_dt == 6'h00) && hdr_vc_ok;
            frame_end_d   = (hdr_dt == 6'h01) && hdr_vc_ok;
            state_d       = WAIT_END;
          end else if ((hdr_dt == DATA_TYPE) && hdr_vc_ok) begin
            line_start_d = 1'b1;
            word_count_d = hdr_wc;
            pay_cnt_d    = hdr_words;
            trail_cnt_d  = hdr_trail;
            state_d      = (hdr_words != 15'd0) ? PAYLOAD : TRAIL;
          end else begin
            state_d = WAIT_END;
          end
        end
      end
      PAYLOAD: begin
        if (!bus.data_valid) begin
          truncated_d = 1'b1;
          state_d     = IDLE;
        end else begin
          image_data_enable_d = 1'b1;
          pay_cnt_d           = pay_cnt_q - 15'd1;
          if (pay_cnt_q == 15'd1) begin
            image_data_d = bus.data & last_mask;
            state_d      = trail_cnt_q ? TRAIL : WAIT_END;
          end else begin
            image_data_d = bus.data;
          end
        end
      end
      TRAIL: begin
        if (!bus.data_valid) begin
          truncated_d = 1'b1;
          state_d     = IDLE;
        end else begin
          trail_cnt_d = 1'b0;
          state_d     = WAIT_END;
        end
      end
      WAIT_END: begin
        if (!bus.data_valid) state_d = IDLE;
      end
      default: state_d = WAIT_END;
    endcase
  end

  // Reset lands in WAIT_END so a burst already in flight is dropped whole.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q             <= WAIT_END;
      pay_cnt_q           <= 15'd0;
      trail_cnt_q         <= 1'b0;
      word_count_q        <= 16'd0;
      image_data_q        <= 32'd0;
      image_data_enable_q <= 1'b0;
      frame_start_q       <= 1'b0;
      frame_end_q         <= 1'b0;
      line_start_q        <= 1'b0;
      truncated_q         <= 1'b0;
    end else begin
      state_q             <= state_d;
      pay_cnt_q           <= pay_cnt_d;
      trail_cnt_q         <= trail_cnt_d;
      word_count_q        <= word_count_d;
      image_data_q        <= image_data_d;
      image_data_enable_q <= image_data_enable_d;
      frame_start_q       <= frame_start_d;
      frame_end_q         <= frame_end_d;
      line_start_q        <= line_start_d;
      truncated_q         <= truncated_d;
    end
  end

  assign bus.image_data        = image_data_q;
  assign bus.image_data_enable = image_data_enable_q;
  assign bus.frame_start       = frame_start_q;
  assign bus.frame_end         = frame_end_q;
  assign bus.line_start        = line_start_q;
  assign bus.packet_word_count = word_count_q;
  assign bus.truncated         = truncated_q;
endmodule

// File: tb/tb_csi2_packet_extractor.sv
// Directed-vector bench for csi2_packet_extractor with hand-computed expectations.
module tb_csi2_packet_extractor;
  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  csi2_packet_extractor_if bus ();

  csi2_packet_extractor #(
    .DATA_TYPE      (6'h24),
    .VIRTUAL_CHANNEL(2'd0)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int          n_vec = 0;
  int          n_err = 0;
  int          n_fs, n_fe, n_ls, n_tr;
  logic [31:0] pay_q[$];
  logic [31:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_tally();
    n_fs = 0; n_fe = 0; n_ls = 0; n_tr = 0;
    pay_q.delete();
    exp_q.delete();
  endtask

  // Apply one word, then sample the registered response 1ns after the edge.
  task automatic step(input logic [31:0] d, input logic v);
    @(negedge clock);
    bus.data       = d;
    bus.data_valid = v;
    @(posedge clock);
    #1;
    if (bus.image_data_enable === 1'b1) pay_q.push_back(bus.image_data);
    n_fs += int'(bus.frame_start === 1'b1);
    n_fe += int'(bus.frame_end === 1'b1);
    n_ls += int'(bus.line_start === 1'b1);
    n_tr += int'(bus.truncated === 1'b1);
  endtask

  task automatic check_payload(input string tag);
    check_val($sformatf("%s_count", tag), 32'(pay_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < pay_q.size(); i++)
      check_val($sformatf("%s_w%0d", tag, i), pay_q[i], exp_q[i]);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_image_data"}, bus.image_data, 32'd0);
    check_val({tag, "_wc"}, {16'd0, bus.packet_word_count}, 32'd0);
    check_val({tag, "_ctrl"},
              {27'd0, bus.image_data_enable, bus.frame_start, bus.frame_end,
               bus.line_start, bus.truncated}, 32'd0);
  endtask

  initial begin
    reset          = 1'b1;
    bus.data       = 32'd0;
    bus.data_valid = 1'b0;
    clear_tally();
    step(32'd0, 1'b0);
    step(32'd0, 1'b0);
    check_all_zero("reset");
    reset = 1'b0;
    step(32'd0, 1'b0);

    // RGB888 line, WC=12: three payload words then a separate CRC word
    clear_tally();
    exp_q = '{32'h1122_3344, 32'h5566_7788, 32'h99AA_BBCC};
    step(32'h0000_0C24, 1'b1);
    check_val("s1_line_start", {31'd0, bus.line_start}, 32'd1);
    check_val("s1_wc", {16'd0, bus.packet_word_count}, 32'd12);
    step(32'h1122_3344, 1'b1);
    check_val("s1_first_enable", {31'd0, bus.image_data_enable}, 32'd1);
    check_val("s1_line_start_single", {31'd0, bus.line_start}, 32'd0);
    step(32'h5566_7788, 1'b1);
    step(32'h99AA_BBCC, 1'b1);
    step(32'hDEAD_BEEF, 1'b1);
    check_val("s1_crc_not_emitted", {31'd0, bus.image_data_enable}, 32'd0);
    check_val("s1_data_hold", bus.image_data, 32'h99AA_BBCC);
    step(32'd0, 1'b0);
    check_payload("s1_payload");
    check_val("s1_ls_count", 32'(n_ls), 32'd1);

    // WC=6: last word keeps bytes 0..1, CRC shares that word
    clear_tally();
    exp_q = '{32'hDDCC_BBAA, 32'h0000_2211};
    step(32'h0000_0624, 1'b1);
    step(32'hDDCC_BBAA, 1'b1);
    step(32'h4433_2211, 1'b1);
    step(32'h5A5A_5A5A, 1'b1);
    check_val("s2_extra_not_emitted", {31'd0, bus.image_data_enable}, 32'd0);
    step(32'd0, 1'b0);
    check_payload("s2_payload");
    check_val("s2_wc", {16'd0, bus.packet_word_count}, 32'd6);

    // Short packets and filtering by DT / VC
    clear_tally();
    step(32'h0000_0000, 1'b1);
    check_val("s3_fs_vc0", {31'd0, bus.frame_start}, 32'd1);
    step(32'd0, 1'b0);
    check_val("s3_fs_single", {31'd0, bus.frame_start}, 32'd0);
    step(32'h0000_0041, 1'b1);
    step(32'd0, 1'b0);
    check_val("s3_fe_vc1_ignored", 32'(n_fe), 32'd0);
    step(32'h0000_0001, 1'b1);
    check_val("s3_fe_vc0", {31'd0, bus.frame_end}, 32'd1);
    step(32'd0, 1'b0);
    step(32'h0000_082A, 1'b1);
    step(32'h1111_1111, 1'b1);
    step(32'h2222_2222, 1'b1);
    step(32'h3333_3333, 1'b1);
    step(32'd0, 1'b0);
    step(32'h0000_0464, 1'b1);
    step(32'h4444_4444, 1'b1);
    step(32'h5555_5555, 1'b1);
    step(32'd0, 1'b0);
    check_val("s3_no_enables", 32'(pay_q.size()), 32'd0);
    check_val("s3_no_line_start", 32'(n_ls), 32'd0);
    check_val("s3_wc_held", {16'd0, bus.packet_word_count}, 32'd6);
    check_val("s3_fs_count", 32'(n_fs), 32'd1);

    // Truncation after 5 of 12 payload words, then a header straight from IDLE
    clear_tally();
    step(32'h0000_3024, 1'b1);
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(32'hA0A0_A000 + 32'(i));
      step(32'hA0A0_A000 + 32'(i), 1'b1);
    end
    step(32'd0, 1'b0);
    check_val("s4_truncated", {31'd0, bus.truncated}, 32'd1);
    check_val("s4_no_enable_at_drop", {31'd0, bus.image_data_enable}, 32'd0);
    step(32'h0000_0424, 1'b1);
    check_val("s4_truncated_single", {31'd0, bus.truncated}, 32'd0);
    check_val("s4_next_line_start", {31'd0, bus.line_start}, 32'd1);
    check_val("s4_next_wc", {16'd0, bus.packet_word_count}, 32'd4);
    exp_q.push_back(32'hCAFE_F00D);
    step(32'hCAFE_F00D, 1'b1);
    step(32'h0BAD_C0DE, 1'b1);
    step(32'd0, 1'b0);
    check_payload("s4_payload");
    check_val("s4_tr_count", 32'(n_tr), 32'd1);

    // WC=0 long packet: header then CRC only
    clear_tally();
    step(32'h0000_0024, 1'b1);
    check_val("s6_line_start", {31'd0, bus.line_start}, 32'd1);
    check_val("s6_wc", {16'd0, bus.packet_word_count}, 32'd0);
    step(32'h1234_5678, 1'b1);
    step(32'd0, 1'b0);
    step(32'h0000_0000, 1'b1);
    check_val("s6_back_in_idle", {31'd0, bus.frame_start}, 32'd1);
    step(32'd0, 1'b0);
    check_val("s6_no_enables", 32'(pay_q.size()), 32'd0);
    check_val("s6_no_truncated", 32'(n_tr), 32'd0);

    // Reset during payload word 2 of 3 with data_valid held high
    clear_tally();
    exp_q = '{32'h0101_0101};
    step(32'h0000_0C24, 1'b1);
    step(32'h0101_0101, 1'b1);
    reset = 1'b1;
    step(32'h0202_0202, 1'b1);
    check_all_zero("s5_reset");
    reset = 1'b0;
    step(32'h0303_0303, 1'b1);
    step(32'h0404_0404, 1'b1);
    step(32'd0, 1'b0);
    step(32'h0000_0001, 1'b1);
    check_val("s5_next_header", {31'd0, bus.frame_end}, 32'd1);
    step(32'd0, 1'b0);
    check_payload("s5_payload");
    check_val("s5_no_truncated", 32'(n_tr), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
